msrr_rot_ctrl: RTL
==================

Name: msrr_rot_ctrl

Overview:
Sequencer for the 8-bit multifunction rotate register (modes: hold / rotate-right-1 / rotate-right-2 / parallel load).
- Accepts a command (data word, rotate amount, direction) over a valid/ready handshake.
- Loads the word, then issues the minimum sequence of rotate-by-2 and rotate-by-1 steps.
- Returns the rotated result over a second valid/ready handshake.
- Sits between the command source and the rotate register, and is the only driver of the register's mode and load inputs.

Parameters:
WIDTH, 8, datapath width; must equal 2**AMT_W
AMT_W, 3, rotate-amount width
CNT_W, 16, completed-operation counter width

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_data  input  WIDTH  word to rotate
cmd_amt  input  AMT_W  rotate amount, 0..WIDTH-1
cmd_left  input  1  1 = rotate left, 0 = rotate right
rr_mode  output  2  rotate-register mode: 00 hold, 01 ror1, 10 ror2, 11 load rr_sln
rr_sln  output  WIDTH  rotate-register load value
rr_po  input  WIDTH  rotate-register output
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  WIDTH  rotated result
busy  output  1  high whenever state != IDLE
op_count  output  CNT_W  completed operations, wraps

Behaviour:
- The controlled register captures on the rising clk edge according to rr_mode.
- States: IDLE, LOAD, ROT, RESP.
- rr_mode, cmd_ready, res_valid and busy are combinational decodes of state and the remaining-amount counter; they do not depend on cmd_* inputs.
- Reset (async, any state, including mid-operation):
  - state = IDLE, rem = 0, data_r = 0, op_count = 0.
  - Outputs therefore read cmd_ready = 1, rr_mode = 00, rr_sln = 0, res_valid = 0, busy = 0, res_data = 0.
  - The register contents are not cleared by the controller.
- IDLE:
  - cmd_ready = 1, rr_mode = 00.
  - On cmd_valid & cmd_ready: data_r <= cmd_data, rem <= cmd_left ? (0 - cmd_amt) mod WIDTH : cmd_amt; go to LOAD.
  - Left-rotate amount 0 maps to 0.
- LOAD (exactly 1 cycle):
  - rr_mode = 11, rr_sln = data_r.
  - Next state: ROT if rem != 0, else RESP.
- ROT, one cycle per step:
  - rem >= 2: rr_mode = 10, rem <= rem - 2.
  - rem == 1: rr_mode = 01, rem <= 0.
  - Leave for RESP when the step just issued brings rem to 0.
  - Step count = floor(n/2) + (n mod 2); maximum 4 for WIDTH = 8.
- RESP:
  - rr_mode = 00, res_valid = 1, res_data = rr_po, held stable until res_ready.
  - On res_valid & res_ready: op_count <= op_count + 1 (wraps 2**CNT_W-1 -> 0); go to IDLE.
- Latency:
  - Accept edge at cycle T; res_valid first high in cycle T + 2 + steps.
  - Minimum 2 cycles (n = 0); maximum 6 cycles (n = 7).
- Throughput: cmd_ready is low in LOAD/ROT/RESP. At least one IDLE cycle separates operations.
- cmd_* inputs are ignored while cmd_ready = 0; the captured data_r/rem are never disturbed mid-operation.
- res_ready asserted outside RESP has no effect.
- rr_sln = data_r in all states. The value only matters while rr_mode = 11.
- No illegal states are reachable. Any encoding outside the four states decodes to IDLE on the next edge.

Decomposition:
- Shared package msrr_pkg:
  - rr_mode_e enum (RR_HOLD = 2'b00, RR_ROR1 = 2'b01, RR_ROR2 = 2'b10, RR_LOAD = 2'b11).
  - ctrl_state_e enum (IDLE, LOAD, ROT, RESP).
  - Default-width localparams.
- No sub-module required.
- Bench-side model msrr_model (behavioural register honouring rr_mode) is needed for closed-loop tests only; it is not instantiated in RTL.

Test Plan:
- Reset then right rotate: cmd_data = 0xB4, cmd_amt = 3, cmd_left = 0.
  - rr_mode sequence 11, 10, 01.
  - res_valid at T+4, res_data = 0x96.
- Left rotate: cmd_data = 0x81, cmd_amt = 1, cmd_left = 1.
  - Converted amount 7; rr_mode sequence 11, 10, 10, 10, 01.
  - res_valid at T+6, res_data = 0x03.
- Zero amount: cmd_data = 0x5A, cmd_amt = 0, both directions.
  - rr_mode sequence 11 only; res_valid at T+2, res_data = 0x5A.
- Backpressure: res_ready low 5 cycles during RESP.
  - res_valid stays 1, res_data stable, rr_mode = 00, cmd_ready = 0, op_count unchanged.
  - Increments by 1 on the handshake edge.
- Async reset asserted mid-ROT (between clock edges).
  - Outputs go immediately to IDLE values.
  - After release, a new command 0x01 amt 2 right gives 0x40.
- op_count wrap: preload via 65535 completed operations (or force CNT_W = 4, 15 operations).
  - The next completion yields op_count = 0.
  - cmd_valid held high continuously shows one IDLE bubble between operations.

Source files
------------

// File: rtl/msrr_pkg.sv
// Shared types and default widths for the multifunction rotate register sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package msrr_pkg;

    localparam int MSRR_WIDTH = 8;
    localparam int MSRR_AMT_W = 3;
    localparam int MSRR_CNT_W = 16;

    // Rotate-register mode encoding as seen on its select inputs.
    typedef enum logic [1:0] {
        RR_HOLD = 2'b00,
        RR_ROR1 = 2'b01,
        RR_ROR2 = 2'b10,
        RR_LOAD = 2'b11
    } rr_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ROT  = 2'b10,
        RESP = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/msrr_rot_ctrl.sv
// Sequencer: loads a word into the rotate register, then issues minimal ror2/ror1 steps.
// Latency: result valid 2 + ceil(n/2) cycles after the accept edge (2..6 for WIDTH=8).
// Backpressure: one command in flight; cmd_ready low until result handshake completes.
module msrr_rot_ctrl
    import msrr_pkg::*;
#(
    parameter int WIDTH = MSRR_WIDTH,
    parameter int AMT_W = MSRR_AMT_W,
    parameter int CNT_W = MSRR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_left,
    output logic [1:0]       rr_mode,
    output logic [WIDTH-1:0] rr_sln,
    input  logic [WIDTH-1:0] rr_po,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    ctrl_state_e      state, state_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] data_r;
    logic             cmd_take;
    logic             res_take;
    rr_mode_e         mode;

    // State, remaining amount, captured word and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            data_r   <= '0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (cmd_take) begin
                data_r <= cmd_data;
            end
            if (res_take) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode; modes depend only on state and rem.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        mode      = RR_HOLD;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        cmd_take  = 1'b0;
        res_take  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_take  = 1'b1;
                    // A left rotate by k equals a right rotate by WIDTH-k; k=0 stays 0.
                    rem_nxt   = cmd_left ? (AMT_W'(0) - cmd_amt) : cmd_amt;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                mode      = RR_LOAD;
                state_nxt = (rem != '0) ? ROT : RESP;
            end
            ROT: begin
                if (rem >= AMT_W'(2)) begin
                    mode    = RR_ROR2;
                    rem_nxt = rem - AMT_W'(2);
                end else begin
                    mode    = (rem == AMT_W'(1)) ? RR_ROR1 : RR_HOLD;
                    rem_nxt = '0;
                end
                if (rem_nxt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rr_mode  = mode;
    assign rr_sln   = data_r;
    assign busy     = (state != IDLE);
    assign res_data = (state == RESP) ? rr_po : '0;

endmodule
